// File: rtl/serial_pkg.sv
// Shared constants and state encoding for the serial line receiver.
package serial_pkg;

    localparam logic [7:0] CHAR_CR  = 8'h0D;
    localparam logic [7:0] CHAR_LF  = 8'h0A;
    localparam logic [7:0] CHAR_BS  = 8'h08;
    localparam logic [7:0] CHAR_DEL = 8'h7F;

    typedef enum logic [1:0] {
        RECV,
        LOAD,
        DRAIN
    } state_e;

endpackage

// File: rtl/line_buf_ram.sv
// DEPTH x 8 simple dual-port RAM: synchronous write, registered read (EBR friendly).
module line_buf_ram #(
    parameter int unsigned DEPTH = 64,
    localparam int unsigned AW = $clog2(DEPTH)
) (
    input  logic          clk_i,
    input  logic          wr_en_i,
    input  logic [AW-1:0] wr_addr_i,
    input  logic [7:0]    wr_data_i,
    input  logic          rd_en_i,
    input  logic [AW-1:0] rd_addr_i,
    output logic [7:0]    rd_data_o
);

    logic [7:0] mem_q [DEPTH];
    logic [7:0] rd_data_q;

    // Write port and registered read port; the read register holds when rd_en_i is low.
    always_ff @(posedge clk_i) begin
        if (wr_en_i) begin
            mem_q[wr_addr_i] <= wr_data_i;
        end
        if (rd_en_i) begin
            rd_data_q <= mem_q[rd_addr_i];
        end
    end

    assign rd_data_o = rd_data_q;

endmodule

// File: rtl/serial_line_rx.sv
// Line assembler: collects bytes with backspace editing, replays a line on CR/LF.
module serial_line_rx
    import serial_pkg::*;
#(
    parameter int unsigned DEPTH      = 64,
    parameter bit          DROP_EMPTY = 1'b1,
    localparam int unsigned CW = $clog2(DEPTH + 1),
    localparam int unsigned PW = $clog2(DEPTH)
) (
    input  logic          clk_48mhz,
    input  logic          reset,
    input  logic [7:0]    uart_out_data,
    input  logic          uart_out_valid,
    output logic          uart_out_ready,
    output logic [7:0]    line_data,
    output logic          line_valid,
    input  logic          line_ready,
    output logic          line_last,
    output logic [CW-1:0] line_len,
    output logic          line_overflow,
    output logic          line_empty
);

    state_e        state_q, state_d;
    logic [CW-1:0] count_q, count_d;
    logic          ovf_q, ovf_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] len_q, len_d;
    logic          lovf_q, lovf_d;
    logic          empty_q, empty_d;

    logic          in_hs, out_hs;
    logic          is_term, is_bs;
    logic          ram_wr_en, ram_rd_en;
    logic [PW-1:0] ram_rd_addr;
    logic [7:0]    ram_rd_data;

    assign is_term = (uart_out_data == CHAR_CR) || (uart_out_data == CHAR_LF);
    assign is_bs   = (uart_out_data == CHAR_BS) || (uart_out_data == CHAR_DEL);

    // Ready is forced low while reset is held, even though the state already reads RECV.
    assign uart_out_ready = (state_q == RECV) && !reset;
    assign line_valid     = (state_q == DRAIN);
    assign line_last      = line_valid && (CW'(rd_ptr_q) == len_q - CW'(1));
    assign line_data      = line_valid ? ram_rd_data : 8'h00;
    assign line_len       = len_q;
    assign line_overflow  = lovf_q;
    assign line_empty     = empty_q;

    assign in_hs  = uart_out_valid && uart_out_ready;
    assign out_hs = line_valid && line_ready;

    // Next-state logic for the receive/load/drain sequencer and its counters.
    always_comb begin
        state_d     = state_q;
        count_d     = count_q;
        ovf_d       = ovf_q;
        rd_ptr_d    = rd_ptr_q;
        len_d       = len_q;
        lovf_d      = lovf_q;
        empty_d     = 1'b0;
        ram_wr_en   = 1'b0;
        ram_rd_en   = 1'b0;
        ram_rd_addr = rd_ptr_q + PW'(1);

        unique case (state_q)
            RECV: begin
                if (in_hs) begin
                    if (is_term) begin
                        if ((count_q != '0) || !DROP_EMPTY) begin
                            len_d  = count_q;
                            lovf_d = ovf_q;
                            if (count_q == '0) begin
                                empty_d = 1'b1;
                                ovf_d   = 1'b0;
                            end else begin
                                state_d = LOAD;
                            end
                        end
                    end else if (is_bs) begin
                        if (count_q != '0) begin
                            count_d = count_q - CW'(1);
                        end
                    end else if (count_q < CW'(DEPTH)) begin
                        ram_wr_en = 1'b1;
                        count_d   = count_q + CW'(1);
                    end else begin
                        ovf_d = 1'b1;
                    end
                end
            end
            LOAD: begin
                ram_rd_en   = 1'b1;
                ram_rd_addr = '0;
                rd_ptr_d    = '0;
                state_d     = DRAIN;
            end
            DRAIN: begin
                if (out_hs) begin
                    if (line_last) begin
                        count_d = '0;
                        ovf_d   = 1'b0;
                        state_d = RECV;
                    end else begin
                        // Prefetch the next byte so the stream has no bubble.
                        ram_rd_en = 1'b1;
                        rd_ptr_d  = rd_ptr_q + PW'(1);
                    end
                end
            end
            default: state_d = RECV;
        endcase
    end

    // State and counter registers with asynchronous reset.
    always_ff @(posedge clk_48mhz or posedge reset) begin
        if (reset) begin
            state_q  <= RECV;
            count_q  <= '0;
            ovf_q    <= 1'b0;
            rd_ptr_q <= '0;
            len_q    <= '0;
            lovf_q   <= 1'b0;
            empty_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            count_q  <= count_d;
            ovf_q    <= ovf_d;
            rd_ptr_q <= rd_ptr_d;
            len_q    <= len_d;
            lovf_q   <= lovf_d;
            empty_q  <= empty_d;
        end
    end

    line_buf_ram #(
        .DEPTH(DEPTH)
    ) u_buf (
        .clk_i    (clk_48mhz),
        .wr_en_i  (ram_wr_en),
        .wr_addr_i(count_q[PW-1:0]),
        .wr_data_i(uart_out_data),
        .rd_en_i  (ram_rd_en),
        .rd_addr_i(ram_rd_addr),
        .rd_data_o(ram_rd_data)
    );

endmodule

// File: tb/tb_serial_line_rx.sv
// Randomized bench for serial_line_rx: two instances (DROP_EMPTY=1 and 0) share stimulus.
module tb_serial_line_rx;

    localparam int DEPTH = 64;
    localparam int CW    = $clog2(DEPTH + 1);

    logic          clk = 1'b0;
    logic          reset;
    logic [7:0]    in_data;
    logic          in_valid;
    logic          line_ready;

    logic          rdy_a, val_a, last_a, ovf_a, emp_a;
    logic [7:0]    dat_a;
    logic [CW-1:0] len_a;
    logic          rdy_b, val_b, last_b, ovf_b, emp_b;
    logic [7:0]    dat_b;
    logic [CW-1:0] len_b;

    serial_line_rx #(.DEPTH(DEPTH), .DROP_EMPTY(1'b1)) dut_a (
        .clk_48mhz     (clk),
        .reset         (reset),
        .uart_out_data (in_data),
        .uart_out_valid(in_valid),
        .uart_out_ready(rdy_a),
        .line_data     (dat_a),
        .line_valid    (val_a),
        .line_ready    (line_ready),
        .line_last     (last_a),
        .line_len      (len_a),
        .line_overflow (ovf_a),
        .line_empty    (emp_a)
    );

    serial_line_rx #(.DEPTH(DEPTH), .DROP_EMPTY(1'b0)) dut_b (
        .clk_48mhz     (clk),
        .reset         (reset),
        .uart_out_data (in_data),
        .uart_out_valid(in_valid),
        .uart_out_ready(rdy_b),
        .line_data     (dat_b),
        .line_valid    (val_b),
        .line_ready    (line_ready),
        .line_last     (last_b),
        .line_len      (len_b),
        .line_overflow (ovf_b),
        .line_empty    (emp_b)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks   = 0;
    int failures = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    // Reference model: the line being typed plus expected output lines per instance.
    logic [7:0] cur[$];
    bit         ovf_m_a, ovf_m_b;
    logic [7:0] exp_bytes_a[$], exp_bytes_b[$];
    int         exp_len_a[$], exp_len_b[$];
    bit         exp_ovf_a[$], exp_ovf_b[$];

    function automatic void model_byte(input logic [7:0] b);
        if (b == 8'h0D || b == 8'h0A) begin
            if (cur.size() > 0) begin
                foreach (cur[i]) begin
                    exp_bytes_a.push_back(cur[i]);
                    exp_bytes_b.push_back(cur[i]);
                end
                exp_len_a.push_back(cur.size());
                exp_len_b.push_back(cur.size());
                exp_ovf_a.push_back(ovf_m_a);
                exp_ovf_b.push_back(ovf_m_b);
                cur.delete();
                ovf_m_a = 0;
                ovf_m_b = 0;
            end else begin
                exp_len_b.push_back(0);
                exp_ovf_b.push_back(ovf_m_b);
                ovf_m_b = 0;
            end
        end else if (b == 8'h08 || b == 8'h7F) begin
            if (cur.size() > 0) void'(cur.pop_back());
        end else if (cur.size() < DEPTH) begin
            cur.push_back(b);
        end else begin
            ovf_m_a = 1;
            ovf_m_b = 1;
        end
    endfunction

    function automatic void model_clear();
        cur.delete();
        ovf_m_a = 0;
        ovf_m_b = 0;
        exp_bytes_a.delete();
        exp_bytes_b.delete();
        exp_len_a.delete();
        exp_len_b.delete();
        exp_ovf_a.delete();
        exp_ovf_b.delete();
    endfunction

    // Consumer-side backpressure.
    bit bp_en = 0;
    initial begin
        line_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            line_ready = bp_en ? 1'($urandom_range(0, 1)) : 1'b1;
        end
    end

    // Monitor for the DROP_EMPTY=1 instance.
    int         beats_a   = 0;
    int         last_hs_a = 0;
    bit         stall_a   = 0;
    logic [7:0] pd_a;
    logic       pl_a;
    initial begin
        forever begin
            @(negedge clk);
            if (reset) begin
                beats_a = 0;
                stall_a = 0;
            end else begin
                if (val_a) check("ready_low_in_drain_a", 32'(rdy_a), 0);
                if (stall_a) begin
                    check("hold_valid_a", 32'(val_a), 1);
                    check("hold_data_a", 32'(dat_a), 32'(pd_a));
                    check("hold_last_a", 32'(last_a), 32'(pl_a));
                end
                if (emp_a) check("empty_pulse_a", 32'(emp_a), 0);
                if (val_a && line_ready) begin
                    if (exp_len_a.size() == 0 || exp_bytes_a.size() == 0) begin
                        check("extra_beat_a", 1, 0);
                    end else begin
                        check("data_a", 32'(dat_a), 32'(exp_bytes_a.pop_front()));
                        check("len_a", 32'(len_a), exp_len_a[0]);
                        check("ovf_a", 32'(ovf_a), 32'(exp_ovf_a[0]));
                        beats_a++;
                        check("last_a", 32'(last_a), 32'(beats_a == exp_len_a[0]));
                        if (beats_a == exp_len_a[0]) begin
                            void'(exp_len_a.pop_front());
                            void'(exp_ovf_a.pop_front());
                            beats_a   = 0;
                            last_hs_a = cyc + 1;
                        end
                    end
                end
                stall_a = val_a && !line_ready;
                pd_a    = dat_a;
                pl_a    = last_a;
            end
        end
    end

    // Monitor for the DROP_EMPTY=0 instance, including empty-line pulses.
    int beats_b = 0;
    initial begin
        forever begin
            @(negedge clk);
            if (reset) begin
                beats_b = 0;
            end else begin
                if (val_b) check("ready_low_in_drain_b", 32'(rdy_b), 0);
                if (emp_b) begin
                    if (exp_len_b.size() == 0) begin
                        check("extra_empty_b", 1, 0);
                    end else begin
                        check("empty_len_b", 32'(len_b), exp_len_b[0]);
                        check("empty_ovf_b", 32'(ovf_b), 32'(exp_ovf_b[0]));
                        void'(exp_len_b.pop_front());
                        void'(exp_ovf_b.pop_front());
                    end
                end
                if (val_b && line_ready) begin
                    if (exp_len_b.size() == 0 || exp_bytes_b.size() == 0) begin
                        check("extra_beat_b", 1, 0);
                    end else begin
                        check("data_b", 32'(dat_b), 32'(exp_bytes_b.pop_front()));
                        check("len_b", 32'(len_b), exp_len_b[0]);
                        check("ovf_b", 32'(ovf_b), 32'(exp_ovf_b[0]));
                        beats_b++;
                        check("last_b", 32'(last_b), 32'(beats_b == exp_len_b[0]));
                        if (beats_b == exp_len_b[0]) begin
                            void'(exp_len_b.pop_front());
                            void'(exp_ovf_b.pop_front());
                            beats_b = 0;
                        end
                    end
                end
            end
        end
    end

    // Offer one byte; returns the post-edge cycle number of its acceptance.
    task automatic send_byte(input logic [7:0] b, output int acc);
        int n;
        n        = 0;
        acc      = -1;
        in_data  = b;
        in_valid = 1'b1;
        @(negedge clk);
        while (!rdy_a && n < 3000) begin
            n++;
            @(negedge clk);
        end
        if (!rdy_a) begin
            check("send_timeout", 0, 1);
            in_valid = 1'b0;
        end else begin
            check("ready_b", 32'(rdy_b), 1);
            @(posedge clk);
            #1;
            acc      = cyc;
            in_valid = 1'b0;
            in_data  = 8'($urandom);
            model_byte(b);
        end
    endtask

    task automatic send_str(input string s);
        int acc;
        for (int i = 0; i < s.len(); i++) send_byte(s[i], acc);
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while ((exp_len_a.size() != 0 || exp_len_b.size() != 0 || val_a) && n < 3000) begin
            @(negedge clk);
            n++;
        end
        if (n >= 3000) check("drain_timeout", 0, 1);
        @(posedge clk);
        #1;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int acc;
        int n;
        int len;
        int r;
        logic [7:0] b;

        reset    = 1'b1;
        in_valid = 1'b0;
        in_data  = 8'h00;
        model_clear();
        #13;
        check("rst_ready_a", 32'(rdy_a), 0);
        check("rst_ready_b", 32'(rdy_b), 0);
        check("rst_valid", 32'(val_a), 0);
        check("rst_last", 32'(last_a), 0);
        check("rst_len", 32'(len_a), 0);
        check("rst_ovf", 32'(ovf_a), 0);
        check("rst_empty", 32'(emp_b), 0);
        check("rst_data", 32'(dat_a), 0);
        @(posedge clk);
        #3 reset = 1'b0;
        @(posedge clk);
        #1;
        check("ready_after_reset", 32'(rdy_a), 1);

        // "AB" CR with latency check: LOAD cycle, then data.
        send_str("AB");
        send_byte(8'h0D, acc);
        @(negedge clk);
        check("load_valid", 32'(val_a), 0);
        check("load_ready", 32'(rdy_a), 0);
        @(negedge clk);
        check("first_beat_valid", 32'(val_a), 1);
        wait_idle();
        check("ready_again", 32'(rdy_a), 1);

        // CR LF pair: one line on A; line then empty pulse on B.
        send_str("AB");
        send_byte(8'h0D, acc);
        send_byte(8'h0A, acc);
        wait_idle();

        // Backspace editing, including backspace on an empty buffer.
        send_str("ABC");
        send_byte(8'h08, acc);
        send_byte("D", acc);
        send_byte(8'h0A, acc);
        send_byte(8'h08, acc);
        send_byte(8'h7F, acc);
        send_byte("X", acc);
        send_byte(8'h0D, acc);
        wait_idle();

        // Overflow, exact fill, and backspace after overflow.
        for (int i = 0; i < 70; i++) send_byte(8'(8'h30 + i), acc);
        send_byte(8'h0D, acc);
        wait_idle();
        for (int i = 0; i < DEPTH; i++) send_byte(8'(8'h30 + i), acc);
        send_byte(8'h0D, acc);
        wait_idle();
        for (int i = 0; i < 66; i++) send_byte(8'(8'h40 + i), acc);
        send_byte(8'h7F, acc);
        send_byte(8'h0A, acc);
        wait_idle();

        // Backpressured 10-byte line, then a back-to-back byte.
        bp_en = 1;
        for (int i = 0; i < 10; i++) send_byte(8'($urandom_range(8'h41, 8'h5A)), acc);
        send_byte(8'h0D, acc);
        send_byte("Q", acc);
        check("back_to_back_accept", 32'(acc - last_hs_a), 1);
        send_byte(8'h0D, acc);
        wait_idle();

        // Random lines with editing, terminators and occasional overflow.
        for (int l = 0; l < 25; l++) begin
            len = $urandom_range(0, 75);
            for (int i = 0; i < len; i++) begin
                r = $urandom_range(0, 99);
                if (r < 6) b = 8'h08;
                else if (r < 9) b = 8'h7F;
                else if (r < 11) b = (r == 9) ? 8'h0D : 8'h0A;
                else b = 8'($urandom_range(8'h20, 8'h7E));
                send_byte(b, acc);
            end
            send_byte(($urandom_range(0, 1) == 0) ? 8'h0D : 8'h0A, acc);
        end
        wait_idle();
        bp_en = 0;
        @(posedge clk);
        #1;

        // Asynchronous reset while the third beat of a 5-byte line is presented.
        send_str("12345");
        send_byte(8'h0D, acc);
        n = 0;
        do begin
            @(posedge clk);
            #2;
            n++;
        end while (!(beats_a == 2 && val_a) && n < 200);
        if (n >= 200) check("reset_setup_timeout", 0, 1);
        reset = 1'b1;
        model_clear();
        #1;
        check("reset_drops_valid_a", 32'(val_a), 0);
        check("reset_drops_valid_b", 32'(val_b), 0);
        check("reset_ready_low", 32'(rdy_a), 0);
        @(posedge clk);
        @(posedge clk);
        #3 reset = 1'b0;
        @(posedge clk);
        #1;
        check("post_reset_ready", 32'(rdy_a), 1);
        check("post_reset_len", 32'(len_a), 0);
        check("post_reset_valid", 32'(val_a), 0);
        send_byte("Z", acc);
        send_byte(8'h0D, acc);
        wait_idle();

        check("leftover_lines_a", exp_len_a.size(), 0);
        check("leftover_lines_b", exp_len_b.size(), 0);
        check("leftover_bytes_a", exp_bytes_a.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
